// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants and FSM state type for the voice allocator slice
//
// Contents:
//   NVOICES     number of voice slots (matches the downstream phase bank count)
//   MIDI_W      MIDI note width
//   SLOT_W      slot index width
//   MIDI_SILENT note value that marks a free slot / silent output
//   va_state_t  table-management FSM states
package synth_pkg;

  localparam int NVOICES = 10;
  localparam int MIDI_W  = 7;
  localparam int SLOT_W  = 4;

  localparam logic [MIDI_W-1:0] MIDI_SILENT = 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } va_state_t;

endpackage

// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - note-event handshake bundle for the voice allocator
//
// Signals:
//   i_evt_valid  note event offered by the producer
//   o_evt_ready  allocator can take an event (accept = valid & ready)
//   i_evt_on     1 = note-on, 0 = note-off
//   i_evt_note   MIDI note number
// Modports:
//   master  event producer
//   slave   allocator
interface voice_allocator_if;
  import synth_pkg::*;

  logic              i_evt_valid;
  logic              o_evt_ready;
  logic              i_evt_on;
  logic [MIDI_W-1:0] i_evt_note;

  modport master (
    output i_evt_valid,
    output i_evt_on,
    output i_evt_note,
    input  o_evt_ready
  );

  modport slave (
    input  i_evt_valid,
    input  i_evt_on,
    input  i_evt_note,
    output o_evt_ready
  );

endinterface

// File: rtl/voice_slot_seq.sv
// rtl/voice_slot_seq.sv - round-robin slot pointer and registered slot/note output stream
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clk_en     sample-rate strobe; the only thing that advances this stream
//   rd_data    voice table entry at slot_ptr (combinational read from the table owner)
//   slot_ptr   slot currently being read
//   o_midi     registered note of the presented slot
//   o_slot     registered index of the presented slot
module voice_slot_seq
  import synth_pkg::*;
#(
  parameter int NVOICES = synth_pkg::NVOICES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [MIDI_W-1:0] rd_data,
  output logic [SLOT_W-1:0] slot_ptr,
  output logic [MIDI_W-1:0] o_midi,
  output logic [SLOT_W-1:0] o_slot
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NVOICES - 1);

  // o_slot resets to the last slot so the first strobe after reset presents
  // slot 0, matching a downstream bank index that also resets to the last slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_ptr <= '0;
      o_midi   <= MIDI_SILENT;
      o_slot   <= LAST_SLOT;
    end else if (clk_en) begin
      o_midi   <= rd_data;
      o_slot   <= slot_ptr;
      slot_ptr <= (slot_ptr == LAST_SLOT) ? '0 : slot_ptr + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice table with note-event allocation and slot output stream
//
// Configuration macro: VOICE_STEAL_EN
//   defined   a note-on that finds the table full overwrites slot victim_ptr
//             (round-robin) and pulses o_overflow
//   undefined such a note-on is dropped and o_overflow pulses
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clk_en        sample-rate strobe; advances the output slot stream only
//   evt           note-event handshake (voice_allocator_if.slave)
//   o_midi        note of the presented slot, 0 = silent (to phase bank i_midi)
//   o_slot        index of the slot on o_midi
//   o_active_cnt  number of occupied slots
//   o_overflow    one-clk pulse when a note-on finds no free slot
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NVOICES = synth_pkg::NVOICES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  voice_allocator_if.slave        evt,
  output logic [MIDI_W-1:0]       o_midi,
  output logic [SLOT_W-1:0]       o_slot,
  output logic [SLOT_W-1:0]       o_active_cnt,
  output logic                    o_overflow
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NVOICES - 1);

  va_state_t         state_q, state_d;

  logic [MIDI_W-1:0] voice_tbl [NVOICES];

  // Latched event and scan results
  logic              lat_on;
  logic [MIDI_W-1:0] lat_note;
  logic [SLOT_W-1:0] scan_idx;
  logic              match_found;
  logic [SLOT_W-1:0] match_idx;
  logic              free_found;
  logic [SLOT_W-1:0] free_idx;

  // COMMIT-stage controls from the output decoder
  logic              wr_en;
  logic [SLOT_W-1:0] wr_idx;
  logic [MIDI_W-1:0] wr_data;
  logic              cnt_inc;
  logic              cnt_dec;
  logic              ovf_pulse;

  logic [SLOT_W-1:0] slot_ptr;
  logic [MIDI_W-1:0] slot_rd_data;

`ifdef VOICE_STEAL_EN
  logic [SLOT_W-1:0] victim_ptr;
  logic              steal;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (evt.i_evt_valid) state_d = SCAN;
      SCAN:    if (scan_idx == LAST_SLOT) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / commit decode
  // ---------------------------------------------------------------------------
  always_comb begin
    evt.o_evt_ready = (state_q == IDLE);
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_data   = MIDI_SILENT;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    ovf_pulse = 1'b0;
`ifdef VOICE_STEAL_EN
    steal     = 1'b0;
`endif
    // A silent note would "match" every free slot, so it never touches the table.
    if (state_q == COMMIT && lat_note != MIDI_SILENT) begin
      if (lat_on) begin
        if (!match_found) begin
          if (free_found) begin
            wr_en   = 1'b1;
            wr_idx  = free_idx;
            wr_data = lat_note;
            cnt_inc = 1'b1;
          end else begin
            ovf_pulse = 1'b1;
`ifdef VOICE_STEAL_EN
            // Replacing an occupied slot leaves the active count unchanged.
            steal   = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = victim_ptr;
            wr_data = lat_note;
`endif
          end
        end
      end else if (match_found) begin
        wr_en   = 1'b1;
        wr_idx  = match_idx;
        wr_data = MIDI_SILENT;
        cnt_dec = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event latch and sequential scan (one slot per clk, lowest index wins)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_on      <= 1'b0;
      lat_note    <= MIDI_SILENT;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (evt.i_evt_valid) begin
            lat_on      <= evt.i_evt_on;
            lat_note    <= evt.i_evt_note;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
          end
        end
        SCAN: begin
          scan_idx <= scan_idx + SLOT_W'(1);
          if (!match_found && voice_tbl[scan_idx] == lat_note) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!free_found && voice_tbl[scan_idx] == MIDI_SILENT) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Voice table, active count, overflow pulse, victim pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NVOICES; i++) voice_tbl[i] <= MIDI_SILENT;
      o_active_cnt <= '0;
      o_overflow   <= 1'b0;
`ifdef VOICE_STEAL_EN
      victim_ptr   <= '0;
`endif
    end else begin
      o_overflow <= ovf_pulse;
      if (wr_en) voice_tbl[wr_idx] <= wr_data;
      if (cnt_inc)      o_active_cnt <= o_active_cnt + SLOT_W'(1);
      else if (cnt_dec) o_active_cnt <= o_active_cnt - SLOT_W'(1);
`ifdef VOICE_STEAL_EN
      if (steal) victim_ptr <= (victim_ptr == LAST_SLOT) ? '0 : victim_ptr + SLOT_W'(1);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output slot stream; the read sees the table before any same-clk commit,
  // so a freshly written note appears on the slot's next visit.
  // ---------------------------------------------------------------------------
  assign slot_rd_data = voice_tbl[slot_ptr];

  voice_slot_seq #(
    .NVOICES (NVOICES)
  ) u_slot_seq (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .rd_data  (slot_rd_data),
    .slot_ptr (slot_ptr),
    .o_midi   (o_midi),
    .o_slot   (o_slot)
  );

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator
module tb_voice_allocator;

  localparam int NV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic [6:0] o_midi;
  logic [3:0] o_slot;
  logic [3:0] o_active_cnt;
  logic       o_overflow;

  voice_allocator_if evt_if ();

  voice_allocator #(.NVOICES(NV)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .evt          (evt_if),
    .o_midi       (o_midi),
    .o_slot       (o_slot),
    .o_active_cnt (o_active_cnt),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] slot;
    logic [6:0] midi;
  } exp_stream_t;

  typedef struct {
    int cnt;
    bit ovf;
  } exp_evt_t;

  exp_stream_t sq[$];
  exp_evt_t    eq[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] model [NV];
  int         exp_ptr = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  bit en_seen = 1'b0;
  int lowcnt  = 0;

  always @(posedge clk) en_seen = clk_en;

  always @(negedge clk) begin
    exp_stream_t s;
    if (en_seen && !rst) begin
      if (sq.size() == 0) check("stream_unexpected", 1, 0);
      else begin
        s = sq.pop_front();
        check("stream_slot", int'(o_slot), int'(s.slot));
        check("stream_midi", int'(o_midi), int'(s.midi));
      end
    end
  end

  always @(negedge clk) begin
    exp_evt_t e;
    if (rst) lowcnt = 0;
    else if (!evt_if.o_evt_ready) lowcnt++;
    else if (lowcnt > 0) begin
      if (eq.size() == 0) check("evt_unexpected", 1, 0);
      else begin
        e = eq.pop_front();
        check("evt_latency", lowcnt, 11);
        check("evt_active_cnt", int'(o_active_cnt), e.cnt);
        check("evt_overflow", int'(o_overflow), int'(e.ovf));
      end
      lowcnt = 0;
    end else begin
      check("stray_overflow", int'(o_overflow), 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_slots(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      clk_en = 1'b1;
      sq.push_back('{slot: 4'(exp_ptr), midi: model[exp_ptr]});
      exp_ptr = (exp_ptr == NV - 1) ? 0 : exp_ptr + 1;
    end
    @(posedge clk); #1;
    clk_en = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!evt_if.o_evt_ready && k < 40);
    check("evt_ready_timeout", int'(evt_if.o_evt_ready), 1);
  endtask

  task automatic issue_evt(input bit on, input logic [6:0] note);
    @(posedge clk); #1;
    evt_if.i_evt_valid = 1'b1;
    evt_if.i_evt_on    = on;
    evt_if.i_evt_note  = note;
    @(posedge clk); #1;
    evt_if.i_evt_valid = 1'b0;
  endtask

  task automatic send_evt(input bit on, input logic [6:0] note, input int exp_cnt, input bit exp_ovf);
    eq.push_back('{cnt: exp_cnt, ovf: exp_ovf});
    issue_evt(on, note);
    wait_ready();
  endtask

  task automatic clear_model();
    for (int i = 0; i < NV; i++) model[i] = 7'h00;
    exp_ptr = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"},  int'(evt_if.o_evt_ready), 1);
    check({tag, "_slot"},   int'(o_slot), NV - 1);
    check({tag, "_midi"},   int'(o_midi), 0);
    check({tag, "_cnt"},    int'(o_active_cnt), 0);
    check({tag, "_ovf"},    int'(o_overflow), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] n;
    evt_if.i_evt_valid = 1'b0;
    evt_if.i_evt_on    = 1'b0;
    evt_if.i_evt_note  = 7'h00;
    clear_model();

    // Reset and idle stream
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    run_slots(NV);
    check("idle_active_cnt", int'(o_active_cnt), 0);

    // Single note-on lands in slot 0
    send_evt(1'b1, 7'h45, 1, 1'b0);
    model[0] = 7'h45;
    run_slots(NV);

    // Duplicate note-on, note-off, unmatched note-off
    send_evt(1'b1, 7'h45, 1, 1'b0);
    send_evt(1'b0, 7'h45, 0, 1'b0);
    model[0] = 7'h00;
    send_evt(1'b0, 7'h30, 0, 1'b0);
    run_slots(NV);

    // Commit to slot 0 on the same clk slot 0 is output (pointer is at 0 here)
    eq.push_back('{cnt: 1, ovf: 1'b0});
    issue_evt(1'b1, 7'h40);
    repeat (10) @(posedge clk);
    #1 clk_en = 1'b1;
    sq.push_back('{slot: 4'(exp_ptr), midi: 7'h00});
    exp_ptr = exp_ptr + 1;
    @(posedge clk);
    #1 clk_en = 1'b0;
    model[0] = 7'h40;
    wait_ready();
    run_slots(NV);

    // Reset while scanning
    issue_evt(1'b1, 7'h22);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    @(negedge clk);
    check_reset_state("scan_reset");
    run_slots(NV);

    // Fill the table, then overflow twice
    for (int i = 0; i < NV; i++) begin
      n = 7'(8'h3C + i);
      send_evt(1'b1, n, i + 1, 1'b0);
      model[i] = n;
    end
    send_evt(1'b1, 7'h50, NV, 1'b1);
    send_evt(1'b1, 7'h51, NV, 1'b1);
`ifdef VOICE_STEAL_EN
    model[0] = 7'h50;
    model[1] = 7'h51;
`endif
    run_slots(NV);

    // Silent-note events are accepted but inert, even with a full table
    send_evt(1'b1, 7'h00, NV, 1'b0);
    send_evt(1'b0, 7'h00, NV, 1'b0);

    // Free two slots, refill reuses the lowest free one
    send_evt(1'b0, 7'h3E, NV - 1, 1'b0);
    model[2] = 7'h00;
    send_evt(1'b0, 7'h40, NV - 2, 1'b0);
    model[4] = 7'h00;
    send_evt(1'b1, 7'h11, NV - 1, 1'b0);
    model[2] = 7'h11;
    run_slots(NV);

    repeat (3) @(negedge clk);
    check("stream_queue_empty", sq.size(), 0);
    check("event_queue_empty", eq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 The block SHALL have parameter NVOICES, default 10, giving the number of voice slots; it SHALL equal the downstream phase bank's bank count.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port clk_en, input, 1 bit: sample-rate strobe; it advances the output slot stream only.
REQ-005 The block SHALL have port i_evt_valid, input, 1 bit: a note event is offered.
REQ-006 The block SHALL have port o_evt_ready, output, 1 bit: an event is accepted when i_evt_valid and o_evt_ready are both high.
REQ-007 The block SHALL have port i_evt_on, input, 1 bit: 1 = note-on, 0 = note-off.
REQ-008 The block SHALL have port i_evt_note, input, 7 bits: MIDI note number.
REQ-009 The block SHALL have port o_midi, output, 7 bits: note of the current slot, 7'h00 = silent; it feeds the phase bank's i_midi.
REQ-010 The block SHALL have port o_slot, output, 4 bits: index of the slot presented on o_midi.
REQ-011 The block SHALL have port o_active_cnt, output, 4 bits: number of occupied slots.
REQ-012 The block SHALL have port o_overflow, output, 1 bit: one-clk pulse when a note-on finds no free slot.

Function
REQ-013 The block SHALL hold a voice table of NVOICES x 7-bit entries; an entry of 0 means free.
REQ-014 The table-management FSM SHALL have states IDLE, SCAN and COMMIT, and SHALL advance every clk independent of clk_en.
REQ-015 In IDLE, o_evt_ready SHALL be 1; on acceptance the FSM SHALL latch on/note, clear the scan index to 0 and go to SCAN; o_evt_ready SHALL be 0 in SCAN and COMMIT.
REQ-016 SCAN SHALL examine one slot per clk, index 0..NVOICES-1, recording the lowest matching slot and the lowest free slot; it SHALL go to COMMIT after index NVOICES-1, so event-to-ready latency is NVOICES+1 clks.
REQ-017 In COMMIT, a note-on whose note already occupies a slot SHALL leave the table unchanged.
REQ-018 In COMMIT, a note-on with no match SHALL write the note to the lowest free slot; if no slot is free, the REQ-029 behaviour applies.
REQ-019 In COMMIT, a note-off SHALL write 0 to the matching slot; a note-off with no match SHALL be ignored.
REQ-020 Any event with note 7'h00 SHALL be accepted and SHALL have no effect on the table.
REQ-021 COMMIT SHALL return to IDLE on the next clk.
REQ-022 o_active_cnt SHALL be updated in the same clk as the table write.
REQ-023 On each clk with clk_en=1, the block SHALL register o_midi <= table[slot_ptr] and o_slot <= slot_ptr, then advance slot_ptr; slot_ptr SHALL wrap from NVOICES-1 to 0.
REQ-024 With clk_en=0, o_midi, o_slot and slot_ptr SHALL hold their values.
REQ-025 If a COMMIT write and an output read of the same slot occur in one clk, o_midi SHALL carry the pre-write value; the new value SHALL appear on that slot's next visit.

Reset
REQ-026 While rst is high, the block SHALL force state IDLE, all table entries 0, slot_ptr 0, o_slot NVOICES-1, o_midi 0, o_active_cnt 0, o_overflow 0 and victim_ptr 0; o_evt_ready SHALL be 1 once rst deasserts.
REQ-027 Reset asserted mid-SCAN or mid-COMMIT SHALL discard the pending event with no partial table write.
REQ-028 After reset, the first clk_en edge SHALL present slot 0, aligning with a downstream bank index that is reset to NVOICES-1.

Configuration
REQ-029 The macro VOICE_STEAL_EN SHALL select full-table behaviour: defined, a note-on with no free slot SHALL overwrite slot victim_ptr, advance victim_ptr modulo NVOICES and pulse o_overflow; undefined, the note-on SHALL be dropped, o_overflow SHALL pulse, and victim_ptr logic SHALL not exist.

Structure
REQ-030 A shared package synth_pkg SHALL hold NVOICES=10, MIDI_W=7, SLOT_W=4, MIDI_SILENT=7'h00 and the FSM state enum.
REQ-031 The slot_ptr/output register path SHALL be one sub-module, voice_slot_seq.

Verification
REQ-032 Reset, then NVOICES clk_en pulses -> o_slot sequence 0..9, o_midi all 0, o_active_cnt 0.
REQ-033 Note-on 0x45 -> o_evt_ready low for 11 clks; slot 0 = 0x45; o_active_cnt 1; 0x45 appears on o_midi whenever o_slot=0.
REQ-034 Note-on 0x45 twice, then note-off 0x45 -> one slot used, then freed; o_active_cnt 1 then 0; note-off 0x30 -> no change.
REQ-035 Ten note-ons 0x3C..0x45, then note-on 0x50 -> VOICE_STEAL_EN defined: slot 0 = 0x50, victim_ptr 1, o_overflow pulse; undefined: table unchanged, o_overflow pulse, o_active_cnt stays 10.
REQ-036 Note-on 0x40 committing on the clk that slot 0 is output -> o_midi 0 that cycle, 0x40 on the next slot-0 visit.
REQ-037 rst asserted during SCAN -> table all 0, o_evt_ready 1 after release, no o_overflow.
